// File: rtl/dmem_arbiter_if.sv
// Handshake bundle for dmem_arbiter: two request masters plus the memory port.
// slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_lock;
    logic [DW-1:0] m0_rdata;
    logic          m0_ack;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic [DW-1:0] m1_rdata;
    logic          m1_ack;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_datain;
    logic          mem_we;
    logic [DW-1:0] mem_dataout;
    logic          busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_rdata, m0_ack,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_rdata, m1_ack,
        output mem_addr, mem_datain, mem_we,
        input  mem_dataout,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_rdata, m0_ack,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_rdata, m1_ack,
        input  mem_addr, mem_datain, mem_we,
        output mem_dataout,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter for the shared data-memory / MMIO port.
// Ports: clock, reset (async, active high), bus (dmem_arbiter_if.slave).
// Optional DMEM_ARB_LOCK_EN: owner lock holds the bus across transactions.
module dmem_arbiter #(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic          r_rr_last;
    logic          r_mem_we;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_datain;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic          w_gnt_vld;
    logic          w_gnt_sel;
    logic          w_hold;

`ifdef DMEM_ARB_LOCK_EN
    logic          r_lock_hold;
    logic          w_own_lock;

    assign w_own_lock = r_owner ? bus.m1_lock : bus.m0_lock;
`else
    logic          w_unused_lock;

    assign w_unused_lock = bus.m0_lock ^ bus.m1_lock;
`endif

    // Grant selection; only acted on in IDLE.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_sel = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        // Hold persists only while the owner keeps both req and lock up.
        w_hold = r_lock_hold &&
                 (r_owner ? (bus.m1_req && bus.m1_lock)
                          : (bus.m0_req && bus.m0_lock));
`else
        w_hold = 1'b0;
`endif
        if (w_hold) begin
            w_gnt_vld = 1'b1;
            w_gnt_sel = r_owner;
        end else if (bus.m0_req && bus.m1_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_sel = ~r_rr_last;
        end else if (bus.m0_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_sel = 1'b0;
        end else if (bus.m1_req) begin
            w_gnt_vld = 1'b1;
            w_gnt_sel = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_gnt_vld) w_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_rr_last    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_cnt        <= 4'd0;
            r_mem_addr   <= '0;
            r_mem_datain <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
`ifdef DMEM_ARB_LOCK_EN
            r_lock_hold  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef DMEM_ARB_LOCK_EN
                    r_lock_hold <= w_hold;
`endif
                    if (w_gnt_vld) begin
                        r_owner      <= w_gnt_sel;
                        r_rr_last    <= w_gnt_sel;
                        r_mem_addr   <= w_gnt_sel ? bus.m1_addr
                                                  : bus.m0_addr;
                        r_mem_datain <= w_gnt_sel ? bus.m1_wdata
                                                  : bus.m0_wdata;
                        // Write strobe lives only in the first ACCESS cycle.
                        r_mem_we     <= w_gnt_sel ? bus.m1_we
                                                  : bus.m0_we;
                        r_cnt        <= CNT_INIT;
                    end
                end
                S_ACCESS: begin
                    r_mem_we <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        if (r_owner) r_m1_rdata <= bus.mem_dataout;
                        else         r_m0_rdata <= bus.mem_dataout;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
`ifdef DMEM_ARB_LOCK_EN
                    if (w_own_lock) r_lock_hold <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_datain = r_mem_datain;
    assign bus.mem_we     = r_mem_we;
    assign bus.m0_rdata   = r_m0_rdata;
    assign bus.m1_rdata   = r_m1_rdata;
    assign bus.m0_ack     = (r_state == S_RESP) && !r_owner;
    assign bus.m1_ack     = (r_state == S_RESP) &&  r_owner;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: LATENCY=1 and LATENCY=3 instances.
// Expected values are hand-derived cycle by cycle.
module tb_dmem_arbiter;
    logic clock;
    logic rst1;
    logic rst3;
    int   total;
    int   bad;

`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    dmem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_lat1 (
        .clock (clock),
        .reset (rst1),
        .bus   (bus1.slave)
    );

    dmem_arbiter #(.LATENCY(3), .AW(32), .DW(32)) u_lat3 (
        .clock (clock),
        .reset (rst3),
        .bus   (bus3.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (2) step();
        total++;
        if (bus1.busy !== 1'b0 || bus1.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_ctl got busy=%b we=%b exp 0 0",
                     bus1.busy, bus1.mem_we);
        end
        total++;
        if (bus1.mem_addr !== 32'h0 || bus1.mem_datain !== 32'h0) begin
            bad++;
            $display("FAIL rst_mem got a=%h d=%h exp 0",
                     bus1.mem_addr, bus1.mem_datain);
        end
        total++;
        if (bus1.m0_ack !== 1'b0 || bus1.m1_ack !== 1'b0 ||
            bus1.m0_rdata !== 32'h0 || bus1.m1_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_m got ack=%b%b exp 00",
                     bus1.m0_ack, bus1.m1_ack);
        end
        total++;
        if (bus3.busy !== 1'b0 || bus3.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst3 got busy=%b exp 0", bus3.busy);
        end
        rst1 = 1'b0;
        rst3 = 1'b0;
    endtask

    task automatic test_read();
        bus1.m0_we       = 1'b0;
        bus1.m0_addr     = 32'h0000_0004;
        bus1.mem_dataout = 32'h1234_5678;
        bus1.m0_req      = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            total++;
            if (bus1.mem_we !== 1'b0) begin
                bad++;
                $display("FAIL rd_we c%0d got=%b exp=0", k, bus1.mem_we);
            end
            total++;
            if (bus1.m0_ack !== (k == 2) || bus1.m1_ack !== 1'b0) begin
                bad++;
                $display("FAIL rd_ack c%0d got=%b%b exp=%b0",
                         k, bus1.m0_ack, bus1.m1_ack, k == 2);
            end
            if (k == 1) begin
                total++;
                if (bus1.mem_addr !== 32'h4) begin
                    bad++;
                    $display("FAIL rd_addr got=%h exp=4", bus1.mem_addr);
                end
            end
            if (k == 2) begin
                total++;
                if (bus1.m0_rdata !== 32'h1234_5678) begin
                    bad++;
                    $display("FAIL rd_data got=%h exp=12345678",
                             bus1.m0_rdata);
                end
                bus1.m0_req = 1'b0;
            end
            if (k == 3) begin
                total++;
                if (bus1.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_idle got=%b exp=0", bus1.busy);
                end
            end
        end
    endtask

    task automatic test_write();
        bus1.m1_we       = 1'b1;
        bus1.m1_addr     = 32'h0000_0088;
        bus1.m1_wdata    = 32'h0000_00A5;
        bus1.mem_dataout = 32'h5A5A_0000;
        bus1.m1_req      = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            total++;
            if (bus1.mem_we !== (k == 1)) begin
                bad++;
                $display("FAIL wr_we c%0d got=%b exp=%b",
                         k, bus1.mem_we, k == 1);
            end
            total++;
            if (bus1.m1_ack !== (k == 2) || bus1.m0_ack !== 1'b0) begin
                bad++;
                $display("FAIL wr_ack c%0d got=%b%b exp=0%b",
                         k, bus1.m0_ack, bus1.m1_ack, k == 2);
            end
            if (k == 1) begin
                total++;
                if (bus1.mem_addr !== 32'h88 ||
                    bus1.mem_datain !== 32'hA5) begin
                    bad++;
                    $display("FAIL wr_bus got a=%h d=%h exp 88 a5",
                             bus1.mem_addr, bus1.mem_datain);
                end
            end
            if (k == 2) begin
                total++;
                if (bus1.m1_rdata !== 32'h5A5A_0000) begin
                    bad++;
                    $display("FAIL wr_rb got=%h exp=5a5a0000",
                             bus1.m1_rdata);
                end
                bus1.m1_req = 1'b0;
                bus1.m1_we  = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        bus1.m0_we   = 1'b0;
        bus1.m1_we   = 1'b0;
        bus1.m0_addr = 32'h100;
        bus1.m1_addr = 32'h200;
        bus1.m0_req  = 1'b1;
        bus1.m1_req  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic e0;
            logic e1;
            logic [31:0] ea;
            step();
            e0 = (k == 2) || (k == 8);
            e1 = (k == 5) || (k == 11);
            total++;
            if (bus1.m0_ack !== e0 || bus1.m1_ack !== e1) begin
                bad++;
                $display("FAIL rr_ack c%0d got=%b%b exp=%b%b",
                         k, bus1.m0_ack, bus1.m1_ack, e0, e1);
            end
            if (k % 3 == 1) begin
                ea = (k == 1 || k == 7) ? 32'h100 : 32'h200;
                total++;
                if (bus1.mem_addr !== ea) begin
                    bad++;
                    $display("FAIL rr_gnt c%0d got=%h exp=%h",
                             k, bus1.mem_addr, ea);
                end
            end
        end
        bus1.m0_req = 1'b0;
        bus1.m1_req = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_latency3();
        bus3.mem_dataout = 32'h5555;
        bus3.m0_we       = 1'b1;
        bus3.m0_addr     = 32'h10;
        bus3.m0_wdata    = 32'hCAFE;
        bus3.m0_req      = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            total++;
            if (bus3.mem_we !== (k == 1)) begin
                bad++;
                $display("FAIL l3w_we c%0d got=%b exp=%b",
                         k, bus3.mem_we, k == 1);
            end
            total++;
            if (bus3.m0_ack !== (k == 4) || bus3.busy !== (k <= 4)) begin
                bad++;
                $display("FAIL l3w_ack c%0d got=%b/%b exp=%b/%b",
                         k, bus3.m0_ack, bus3.busy, k == 4, k <= 4);
            end
            if (k <= 3) begin
                total++;
                if (bus3.mem_addr !== 32'h10 ||
                    bus3.mem_datain !== 32'hCAFE) begin
                    bad++;
                    $display("FAIL l3w_bus c%0d got=%h exp=10",
                             k, bus3.mem_addr);
                end
            end
            if (k == 4) begin
                total++;
                if (bus3.m0_rdata !== 32'h5555) begin
                    bad++;
                    $display("FAIL l3w_rb got=%h exp=5555", bus3.m0_rdata);
                end
                bus3.m0_req = 1'b0;
            end
        end
        bus3.mem_dataout = 32'hCAFE;
        bus3.m0_we       = 1'b0;
        bus3.m0_req      = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            total++;
            if (bus3.mem_we !== 1'b0) begin
                bad++;
                $display("FAIL l3r_we c%0d got=%b exp=0", k, bus3.mem_we);
            end
            total++;
            if (bus3.m0_ack !== (k == 4)) begin
                bad++;
                $display("FAIL l3r_ack c%0d got=%b exp=%b",
                         k, bus3.m0_ack, k == 4);
            end
            if (k == 4) begin
                total++;
                if (bus3.m0_rdata !== 32'hCAFE) begin
                    bad++;
                    $display("FAIL l3r_data got=%h exp=cafe",
                             bus3.m0_rdata);
                end
                bus3.m0_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid();
        bus1.m1_we    = 1'b1;
        bus1.m1_addr  = 32'h44;
        bus1.m1_wdata = 32'h77;
        bus1.m1_req   = 1'b1;
        step();
        total++;
        if (bus1.mem_we !== 1'b1) begin
            bad++;
            $display("FAIL rm_pre got=%b exp=1", bus1.mem_we);
        end
        #2;
        rst1 = 1'b1;
        #1;
        total++;
        if (bus1.busy !== 1'b0 || bus1.mem_we !== 1'b0 ||
            bus1.mem_addr !== 32'h0 || bus1.mem_datain !== 32'h0) begin
            bad++;
            $display("FAIL rm_async got b=%b w=%b a=%h exp 0 0 0",
                     bus1.busy, bus1.mem_we, bus1.mem_addr);
        end
        total++;
        if (bus1.m0_rdata !== 32'h0 || bus1.m1_rdata !== 32'h0) begin
            bad++;
            $display("FAIL rm_rdata got=%h/%h exp 0",
                     bus1.m0_rdata, bus1.m1_rdata);
        end
        bus1.m1_req = 1'b0;
        bus1.m1_we  = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) rst1 = 1'b0;
            total++;
            if (bus1.m0_ack !== 1'b0 || bus1.m1_ack !== 1'b0) begin
                bad++;
                $display("FAIL rm_noack c%0d got=%b%b exp=00",
                         k, bus1.m0_ack, bus1.m1_ack);
            end
        end
        bus1.m0_addr = 32'h100;
        bus1.m1_addr = 32'h200;
        bus1.m0_req  = 1'b1;
        bus1.m1_req  = 1'b1;
        step();
        total++;
        if (bus1.mem_addr !== 32'h100) begin
            bad++;
            $display("FAIL rm_tie got=%h exp=100", bus1.mem_addr);
        end
        step();
        total++;
        if (bus1.m0_ack !== 1'b1 || bus1.m1_ack !== 1'b0) begin
            bad++;
            $display("FAIL rm_tack got=%b%b exp=10",
                     bus1.m0_ack, bus1.m1_ack);
        end
        bus1.m0_req = 1'b0;
        bus1.m1_req = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_lock();
        logic [31:0] ea;
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        bus1.m0_we   = 1'b0;
        bus1.m1_we   = 1'b0;
        bus1.m0_addr = 32'h100;
        bus1.m1_addr = 32'h84;
        bus1.m1_lock = 1'b1;
        bus1.m1_req  = 1'b1;
        step();
        total++;
        if (bus1.mem_addr !== 32'h84) begin
            bad++;
            $display("FAIL lk_g1 got=%h exp=84", bus1.mem_addr);
        end
        bus1.m0_req = 1'b1;
        step();
        total++;
        if (bus1.m1_ack !== 1'b1) begin
            bad++;
            $display("FAIL lk_a1 got=%b exp=1", bus1.m1_ack);
        end
        step();
        step();
        ea = LOCK_EN ? 32'h84 : 32'h100;
        total++;
        if (bus1.mem_addr !== ea) begin
            bad++;
            $display("FAIL lk_g2 got=%h exp=%h", bus1.mem_addr, ea);
        end
        bus1.m1_lock = 1'b0;
        step();
        total++;
        if (bus1.m1_ack !== LOCK_EN || bus1.m0_ack !== !LOCK_EN) begin
            bad++;
            $display("FAIL lk_a2 got=%b%b exp=%b%b",
                     bus1.m0_ack, bus1.m1_ack, !LOCK_EN, LOCK_EN);
        end
        step();
        step();
        ea = LOCK_EN ? 32'h100 : 32'h84;
        total++;
        if (bus1.mem_addr !== ea) begin
            bad++;
            $display("FAIL lk_g3 got=%h exp=%h", bus1.mem_addr, ea);
        end
        bus1.m0_req = 1'b0;
        bus1.m1_req = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst1  = 1'b1;
        rst3  = 1'b1;
        bus1.m0_req = 1'b0; bus1.m0_we = 1'b0; bus1.m0_lock = 1'b0;
        bus1.m0_addr = '0; bus1.m0_wdata = '0;
        bus1.m1_req = 1'b0; bus1.m1_we = 1'b0; bus1.m1_lock = 1'b0;
        bus1.m1_addr = '0; bus1.m1_wdata = '0;
        bus1.mem_dataout = '0;
        bus3.m0_req = 1'b0; bus3.m0_we = 1'b0; bus3.m0_lock = 1'b0;
        bus3.m0_addr = '0; bus3.m0_wdata = '0;
        bus3.m1_req = 1'b0; bus3.m1_we = 1'b0; bus3.m1_lock = 1'b0;
        bus3.m1_addr = '0; bus3.m1_wdata = '0;
        bus3.mem_dataout = '0;
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_latency3();
        test_reset_mid();
        test_lock();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter that shares one data-memory / memory-mapped-IO port.
- Masters: m0 = pipeline MEM stage; m1 = loader/debug port.
- Sits between the masters and the data memory block: the RAM at addr[7]=0; switch/LCD registers at addr[7]=1.
- Registers each access, drives the memory port for LATENCY cycles, and returns read data with a one-cycle ack pulse. Round-robin fairness.

Parameters:
- LATENCY, 1: cycles mem_* are held before mem_dataout is captured; legal range 1..15.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  AW  master 0 byte address.
- m0_wdata  in  DW  master 0 write data.
- m0_lock  in  1  master 0 bus lock (used only with the optional feature).
- m0_rdata  out  DW  master 0 read data; valid while m0_ack=1.
- m0_ack  out  1  master 0 completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_rdata, m1_ack: same as m0_* for master 1.
- mem_addr  out  AW  to memory addr.
- mem_datain  out  DW  to memory datain.
- mem_we  out  1  to memory we.
- mem_dataout  in  DW  from memory dataout.
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- Reset values: state=IDLE, mem_addr=0, mem_datain=0, mem_we=0, m0/m1_rdata=0, m0/m1_ack=0, busy=0, rr_last=1 (so m0 wins the first tie), owner=0, lock_hold=0, cnt=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master != rr_last.
  - On grant: register owner, mem_addr, mem_datain, and a latched we; rr_last<=owner; cnt<=LATENCY-1; go to ACCESS.
- ACCESS:
  - mem_addr and mem_datain are stable throughout.
  - mem_we = latched we in the first ACCESS cycle only; 0 in every other ACCESS cycle.
  - When cnt==0: capture mem_dataout into owner's rdata; go to RESP. Otherwise cnt<=cnt-1.
- RESP:
  - owner's ack=1 for exactly one cycle; the other master's ack stays 0; go to IDLE.
  - Write transactions also ack; rdata then holds whatever was captured (the read-back value).
- Latency: req sampled in cycle t (IDLE) -> ack in cycle t+LATENCY+1. Throughput: one access per LATENCY+2 cycles.
- The requester drops req (or presents its next request) in the cycle after ack. A req still high in the IDLE cycle after ack is treated as a new request.
- Request inputs are sampled only in IDLE. Changes to addr/we/wdata after the grant are ignored.
- A non-owner request is held pending and wins the next IDLE by round-robin.
- rdata registers hold their value until that master's next capture.
- mem_addr and mem_datain keep their last values in IDLE/RESP, which avoids spurious address toggling on the IO decode.
- Address bits pass through unmodified; no alignment check.
- Reset asserted mid-operation: return immediately to reset values. An in-flight write may or may not have reached memory (mem_we is forced low immediately). No ack is issued; the master must reissue.
- busy = (state != IDLE).

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - If the owner's lock is 1 in its RESP cycle, lock_hold<=1.
  - While lock_hold=1, IDLE grants only the owner and the other master is never granted.
  - lock_hold clears in any IDLE cycle where the owner's req=0 or lock=0.
  - Purpose: atomic read-modify-write of LCD registers.
- Without the macro: the lock inputs are ignored (lock_hold logic absent) and arbitration is pure round-robin.

Test Plan:
- LATENCY=1; m0 read, addr 0x00000004, mem_dataout=0x12345678 -> mem_we never high; m0_ack high exactly at t+2; m0_rdata=0x12345678.
- m1 write, addr 0x00000088, wdata 0x000000A5 -> mem_we high exactly one cycle (t+1) with mem_addr=0x88 and mem_datain=0xA5; m1_ack at t+2; m0_ack stays 0.
- m0 and m1 both request continuously from reset:
  - grants alternate m0, m1, m0, m1;
  - acks at t+2, t+5, t+8, t+11;
  - no master is granted twice in a row.
- LATENCY=3; m0 write then read, addr 0x10:
  - mem_we high only in the first ACCESS cycle;
  - ack 4 cycles after the req sample;
  - mem_addr stable for 3 cycles.
- Reset pulse during ACCESS of an m1 write -> all outputs at reset values by the next edge; no ack; the next tie goes to m0.
- DMEM_ARB_LOCK_EN defined; m1 requests with lock=1 twice while m0 requests -> m1 is served twice consecutively. After m1 drops lock, m0 is granted next.
